param_bus_datapath: RTL and testbench
=====================================

// Module: param_bus_datapath
// PURPOSE
//   Parametrised successor to the fixed 16-register datapath: an N-entry, W-bit register file on a
//   shared bus with Y/Z/HI/LO staging registers and a built-in micro-sequencer.
//   The sequencer runs a full Ra,Rb -> Rc ALU transfer (Y load, ALU exec, Z writeback) from a single start pulse.
//   Adds OR/ADD/SUB/NOT and an iterative multiply into HI/LO.
//   Sits between the future control unit and the memory interface (MDR path = ext write port).
// PARAMETERS
//   W        32  data/bus width in bits (>=8)
//   NREGS    16  register count (power of 2, >=4); AW = $clog2(NREGS)
//   ZERO_R0  0   1: R0 reads as 0 and ignores writes
// PORTS
//   clk          in   1   rising-edge clock
//   clr          in   1   synchronous, active-low reset
//   start        in   1   launch op; sampled only when busy=0
//   op           in   3   0 AND, 1 OR, 2 ADD, 3 SUB, 4 NOT(Rb), 5 MUL; 6/7 reserved
//   ra, rb, rc   in   AW  source A, source B, destination
//   ext_we       in   1   external (MDR/in-port) register write
//   ext_addr     in   AW  external write target
//   ext_data     in   W   external write data
//   rd_addr      in   AW  debug/async read address
//   rd_data      out  W   combinational R[rd_addr]
//   bus          out  W   current bus value (0 when no driver)
//   hi, lo       out  W   HI/LO registers
//   zflag        out  1   Z-low == 0 after last op
//   busy         out  1   sequencer not IDLE
//   done         out  1   one-cycle pulse; result visible in R[rc]
//   err_op       out  1   one-cycle pulse; reserved op rejected
// BEHAVIOUR
//   Reset (clr=0 at edge): all R, Y, Z, HI, LO = 0; state=IDLE; busy=done=err_op=zflag=0. Reset mid-op aborts with no writeback.
//   States: IDLE -> LDY -> EXEC -> [MULT x W] -> WB -> IDLE.
//   Edge 0 (IDLE, start=1): latch op/ra/rb/rc, go LDY. A reserved op instead pulses err_op and stays IDLE.
//   LDY: bus=R[ra]; Y<=bus at edge 1.
//   EXEC: bus=R[rb]; non-MUL: Z_lo<=f(Y,bus) at edge 2, go WB.
//     MUL: latches multiplicand/multiplier, go MULT.
//   MULT: one shift-add step per cycle for W cycles; unsigned 2W product in {Z_hi,Z_lo}.
//   WB: bus=Z_lo; R[rc]<=bus.
//     Non-MUL: write at edge 3. MUL: write at edge W+3, and HI<=Z_hi, LO<=Z_lo in the same edge.
//   zflag updates at the WB edge. done=1 in the cycle after the WB edge; busy falls at the same edge.
//   Arithmetic: ADD/SUB modulo 2^W (no carry out). NOT ignores Y. MUL is unsigned.
//   Bus drive is one-hot by construction; in IDLE, bus=0.
//   ext_we is honoured in any state.
//   Same-edge WB and ext_we to the same register: WB wins, ext write is dropped.
//   ext write to ra/rb before that operand is bussed: the new value is used.
//   start while busy=1 is ignored (no queueing). start on the done cycle is accepted (back-to-back).
//   ZERO_R0=1: R0 reads 0 in every path (bus, rd_data); writes to R0 are discarded; a WB to R0 still pulses done.
//   rd_data reflects register contents only (no bypass of the same-edge write).
// TESTING
//   1 Reset: preload R1..R3 via ext_we, then clr=0 for 1 edge -> all rd_data=0, busy=0, hi=lo=0.
//   2 ADD: R1=0x0000_0005, R2=0xFFFF_FFFE, start op=2 ra=1 rb=2 rc=3
//       -> R3=0x0000_0003 at edge 3, done at cycle 3, zflag=0.
//   3 SUB wrap/zero: R1=R2=0x1234_5678, op=3 -> R3=0, zflag=1. R1=0, R2=1 -> R3=0xFFFF_FFFF.
//   4 MUL: R4=0xFFFF_FFFF, R5=0x2, op=5 rc=6 -> hi=0x1, lo=0xFFFF_FFFE, R6=0xFFFF_FFFE, done at cycle W+3=35.
//   5 Conflicts: start during busy is ignored; ext_we to rc on the WB edge -> R[rc]=ALU result;
//       op=6 -> err_op pulse, busy stays 0.
//   6 Reset mid-MUL at cycle 10: no HI/LO/R write, done never pulses; then W=16, NREGS=8, ZERO_R0=1 regression of tests 2-4.

Source files
------------

// File: rtl/param_bus_datapath_if.sv
// Bus-side signal bundle for param_bus_datapath.
// The master side drives commands and external writes; the slave side is the datapath.
interface param_bus_datapath_if #(
    parameter int W  = 32,
    parameter int AW = 4
);
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [AW-1:0] rc;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [W-1:0]  ext_data;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  bus;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          zflag;
    logic          busy;
    logic          done;
    logic          err_op;

    modport master (
        output start, op, ra, rb, rc,
        output ext_we, ext_addr, ext_data, rd_addr,
        input  rd_data, bus, hi, lo, zflag, busy, done, err_op
    );

    modport slave (
        input  start, op, ra, rb, rc,
        input  ext_we, ext_addr, ext_data, rd_addr,
        output rd_data, bus, hi, lo, zflag, busy, done, err_op
    );
endinterface

// File: rtl/param_bus_datapath.sv
// N-entry register file on a shared bus with Y/Z/HI/LO staging and a
// micro-sequencer running Ra,Rb -> Rc transfers, including shift-add multiply.
module param_bus_datapath #(
    parameter int W       = 32,
    parameter int NREGS   = 16,
    parameter int ZERO_R0 = 0
) (
    input logic              clk,
    input logic              clr,
    param_bus_datapath_if.slave bif
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDY,
        S_EXEC,
        S_MULT,
        S_WB
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] ra_q, ra_d;
    logic [AW-1:0] rb_q, rb_d;
    logic [AW-1:0] rc_q, rc_d;
    logic [W-1:0]  y_q, y_d;
    logic [W-1:0]  zlo_q, zlo_d;
    logic [W-1:0]  zhi_q, zhi_d;
    logic [W-1:0]  mcand_q, mcand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic          zflag_q, zflag_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [W-1:0]  regs_q [NREGS];
    logic [W-1:0]  regs_d [NREGS];

    logic [W-1:0]  a_val;
    logic [W-1:0]  b_val;
    logic [W-1:0]  bus_v;
    logic [W-1:0]  alu_v;
    logic [W:0]    sum;

    // Operand reads honour the hard-wired zero register when enabled.
    assign a_val = (ZERO_R0 != 0 && ra_q == '0) ? '0 : regs_q[ra_q];
    assign b_val = (ZERO_R0 != 0 && rb_q == '0) ? '0 : regs_q[rb_q];

    assign bif.rd_data = (ZERO_R0 != 0 && bif.rd_addr == '0) ?
                         '0 : regs_q[bif.rd_addr];
    assign bif.bus     = bus_v;
    assign bif.hi      = hi_q;
    assign bif.lo      = lo_q;
    assign bif.zflag   = zflag_q;
    assign bif.busy    = (state_q != S_IDLE);
    assign bif.done    = done_q;
    assign bif.err_op  = err_q;

    // One bus driver per state; nothing drives it while idle or multiplying.
    always_comb begin
        bus_v = '0;
        unique case (state_q)
            S_LDY:   bus_v = a_val;
            S_EXEC:  bus_v = b_val;
            S_WB:    bus_v = zlo_q;
            default: bus_v = '0;
        endcase
    end

    // Single-cycle ALU on Y and the bus.
    always_comb begin
        alu_v = '0;
        case (op_q)
            3'd0:    alu_v = y_q & bus_v;
            3'd1:    alu_v = y_q | bus_v;
            3'd2:    alu_v = y_q + bus_v;
            3'd3:    alu_v = y_q - bus_v;
            3'd4:    alu_v = ~bus_v;
            default: alu_v = '0;
        endcase
    end

    // Sequencer next-state, staging registers and register-file writes.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        y_d     = y_q;
        zlo_d   = zlo_q;
        zhi_d   = zhi_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        zflag_d = zflag_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        sum     = '0;
        for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];

        // External write first so a same-edge writeback overrides it.
        if (bif.ext_we) regs_d[bif.ext_addr] = bif.ext_data;

        unique case (state_q)
            S_IDLE: begin
                if (bif.start) begin
                    if (bif.op > 3'd5) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = bif.op;
                        ra_d    = bif.ra;
                        rb_d    = bif.rb;
                        rc_d    = bif.rc;
                        state_d = S_LDY;
                    end
                end
            end
            S_LDY: begin
                y_d     = bus_v;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op_q == 3'd5) begin
                    mcand_d = y_q;
                    zlo_d   = bus_v;
                    zhi_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MULT;
                end else begin
                    zlo_d   = alu_v;
                    state_d = S_WB;
                end
            end
            S_MULT: begin
                if (zlo_q[0]) sum = {1'b0, zhi_q} + {1'b0, mcand_q};
                else          sum = {1'b0, zhi_q};
                {zhi_d, zlo_d} = {sum, zlo_q[W-1:1]};
                if (cnt_q == CW'(W - 1)) state_d = S_WB;
                cnt_d = cnt_q + 1'b1;
            end
            S_WB: begin
                regs_d[rc_q] = bus_v;
                zflag_d      = (zlo_q == '0);
                if (op_q == 3'd5) begin
                    hi_d = zhi_q;
                    lo_d = zlo_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (ZERO_R0 != 0) regs_d[0] = '0;
    end

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            y_q     <= '0;
            zlo_q   <= '0;
            zhi_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            zflag_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            y_q     <= y_d;
            zlo_q   <= zlo_d;
            zhi_q   <= zhi_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            zflag_q <= zflag_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
        end
    end
endmodule

// File: tb/tb_param_bus_datapath.sv
// Directed bench for param_bus_datapath: a W=32 instance and a
// W=16/NREGS=8/ZERO_R0=1 instance share clock, clear and stimulus.
module tb_param_bus_datapath;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        sel = 1'b0;
    logic        s_start = 1'b0;
    logic [2:0]  s_op = '0;
    logic [3:0]  s_ra = '0, s_rb = '0, s_rc = '0;
    logic        s_we = 1'b0;
    logic [3:0]  s_waddr = '0;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_raddr = '0;

    logic [31:0] o_rd, o_bus, o_hi, o_lo;
    logic        o_z, o_busy, o_done, o_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    param_bus_datapath_if #(.W(32), .AW(4)) if32 ();
    param_bus_datapath_if #(.W(16), .AW(3)) if16 ();

    param_bus_datapath #(.W(32), .NREGS(16), .ZERO_R0(0)) dut32 (
        .clk(clk), .clr(clr), .bif(if32.slave)
    );
    param_bus_datapath #(.W(16), .NREGS(8), .ZERO_R0(1)) dut16 (
        .clk(clk), .clr(clr), .bif(if16.slave)
    );

    assign if32.start    = s_start & ~sel;
    assign if32.op       = s_op;
    assign if32.ra       = s_ra;
    assign if32.rb       = s_rb;
    assign if32.rc       = s_rc;
    assign if32.ext_we   = s_we & ~sel;
    assign if32.ext_addr = s_waddr;
    assign if32.ext_data = s_wdata;
    assign if32.rd_addr  = s_raddr;

    assign if16.start    = s_start & sel;
    assign if16.op       = s_op;
    assign if16.ra       = s_ra[2:0];
    assign if16.rb       = s_rb[2:0];
    assign if16.rc       = s_rc[2:0];
    assign if16.ext_we   = s_we & sel;
    assign if16.ext_addr = s_waddr[2:0];
    assign if16.ext_data = s_wdata[15:0];
    assign if16.rd_addr  = s_raddr[2:0];

    always_comb begin
        o_rd   = sel ? {16'h0, if16.rd_data} : if32.rd_data;
        o_bus  = sel ? {16'h0, if16.bus}     : if32.bus;
        o_hi   = sel ? {16'h0, if16.hi}      : if32.hi;
        o_lo   = sel ? {16'h0, if16.lo}      : if32.lo;
        o_z    = sel ? if16.zflag  : if32.zflag;
        o_busy = sel ? if16.busy   : if32.busy;
        o_done = sel ? if16.done   : if32.done;
        o_err  = sel ? if16.err_op : if32.err_op;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [31:0] h;
        logic [31:0] l;
        logic        z;
        int          lat;
    } vec_t;

    vec_t v32 [7];
    vec_t v16 [4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        s_we = 1'b1;
        s_waddr = a;
        s_wdata = d;
        @(posedge clk);
        #1;
        s_we = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [3:0] a,
                           input logic [31:0] exp);
        s_raddr = a;
        #1;
        chk(name, o_rd, exp);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!o_done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic launch(input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] c);
        s_start = 1'b1;
        s_op = op;
        s_ra = a;
        s_rb = b;
        s_rc = c;
        @(posedge clk);
        #1;
        s_start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input int lat);
        int n;
        launch(op, a, b, c);
        wait_done(n);
        chk({name, "_lat"}, 32'(n), 32'(lat));
        chk({name, "_busy"}, {31'b0, o_busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_pulse"}, {31'b0, o_done}, 32'd0);
    endtask

    initial begin
        int n;
        int cnt;

        v32[0] = '{3'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 0, 0, 1'b0, 3};
        v32[1] = '{3'd1, 32'hF0F0_0000, 32'h0000_000F, 32'hF0F0_000F, 0, 0, 1'b0, 3};
        v32[2] = '{3'd2, 32'h0000_0005, 32'hFFFF_FFFE, 32'h0000_0003, 0, 0, 1'b0, 3};
        v32[3] = '{3'd3, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 0, 0, 1'b1, 3};
        v32[4] = '{3'd3, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 1'b0, 3};
        v32[5] = '{3'd4, 32'h1234_0000, 32'h0F0F_0000, 32'hF0F0_FFFF, 0, 0, 1'b0, 3};
        v32[6] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE,
                   32'h1, 32'hFFFF_FFFE, 1'b0, 35};

        v16[0] = '{3'd2, 32'h0005, 32'hFFFE, 32'h0003, 0, 0, 1'b0, 3};
        v16[1] = '{3'd3, 32'h1234, 32'h1234, 32'h0000, 0, 0, 1'b1, 3};
        v16[2] = '{3'd3, 32'h0000, 32'h0001, 32'hFFFF, 0, 0, 1'b0, 3};
        v16[3] = '{3'd5, 32'hFFFF, 32'h0002, 32'hFFFE, 32'h1, 32'hFFFE, 1'b0, 19};

        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;

        // Reset clears preloaded registers.
        wr(1, 32'h1111_1111);
        wr(2, 32'h2222_2222);
        wr(3, 32'h3333_3333);
        chk_reg("preload_r2", 2, 32'h2222_2222);
        clr = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b1;
        chk_reg("rst_r1", 1, 32'h0);
        chk_reg("rst_r2", 2, 32'h0);
        chk_reg("rst_r3", 3, 32'h0);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_hi", o_hi, 32'h0);
        chk("rst_lo", o_lo, 32'h0);
        chk("rst_z", {31'b0, o_z}, 32'd0);
        chk("idle_bus", o_bus, 32'h0);

        // W=32 vector table, Ra=1 Rb=2 Rc=3.
        for (int i = 0; i < 7; i++) begin
            wr(1, v32[i].a);
            wr(2, v32[i].b);
            run_op($sformatf("v32_%0d", i), v32[i].op, 1, 2, 3, v32[i].lat);
            chk_reg($sformatf("v32_%0d_r3", i), 3, v32[i].r);
            chk($sformatf("v32_%0d_z", i), {31'b0, o_z}, {31'b0, v32[i].z});
            if (v32[i].op == 3'd5) begin
                chk($sformatf("v32_%0d_hi", i), o_hi, v32[i].h);
                chk($sformatf("v32_%0d_lo", i), o_lo, v32[i].l);
            end
        end

        // start while busy ignored; WB beats ext write; back-to-back start.
        wr(1, 32'h0000_0005);
        wr(2, 32'hFFFF_FFFE);
        wr(7, 32'hAAAA_0000);
        s_start = 1'b1;
        s_op = 3'd2;
        s_ra = 1;
        s_rb = 2;
        s_rc = 3;
        @(posedge clk);
        #1;
        s_op = 3'd1;
        s_rc = 7;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        @(posedge clk);
        #1;
        s_we = 1'b1;
        s_waddr = 3;
        s_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        s_we = 1'b0;
        chk("conf_done", {31'b0, o_done}, 32'd1);
        chk_reg("conf_wb_wins", 3, 32'h0000_0003);
        chk_reg("conf_r7", 7, 32'hAAAA_0000);
        launch(3'd1, 1, 2, 4);
        chk("b2b_busy", {31'b0, o_busy}, 32'd1);
        wait_done(n);
        chk("b2b_lat", 32'(n), 32'd3);
        chk_reg("b2b_r4", 4, 32'hFFFF_FFFF);
        cnt = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (o_done) cnt++;
        end
        chk("no_queued_op", 32'(cnt), 32'd0);
        chk_reg("r7_kept", 7, 32'hAAAA_0000);

        // ext write to Rb before it is bussed is seen by EXEC.
        wr(1, 32'd10);
        wr(2, 32'd1);
        launch(3'd2, 1, 2, 3);
        wr(2, 32'd20);
        wait_done(n);
        chk("fwd_lat", 32'(n), 32'd2);
        chk_reg("fwd_r3", 3, 32'd30);

        // Reserved op.
        launch(3'd6, 1, 2, 3);
        chk("err_pulse", {31'b0, o_err}, 32'd1);
        chk("err_busy", {31'b0, o_busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("err_clear", {31'b0, o_err}, 32'd0);

        // Reset in the middle of a multiply.
        wr(4, 32'hFFFF_FFFF);
        wr(5, 32'h0000_0002);
        wr(6, 32'h0000_1111);
        launch(3'd5, 4, 5, 6);
        repeat (9) @(posedge clk);
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b1;
        cnt = 0;
        repeat (42) begin
            @(posedge clk);
            #1;
            if (o_done) cnt++;
        end
        chk("abort_done", 32'(cnt), 32'd0);
        chk("abort_busy", {31'b0, o_busy}, 32'd0);
        chk("abort_hi", o_hi, 32'h0);
        chk("abort_lo", o_lo, 32'h0);
        chk_reg("abort_r6", 6, 32'h0);

        // W=16, NREGS=8, ZERO_R0=1 instance.
        sel = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            wr(1, v16[i].a);
            wr(2, v16[i].b);
            run_op($sformatf("v16_%0d", i), v16[i].op, 1, 2, 3, v16[i].lat);
            chk_reg($sformatf("v16_%0d_r3", i), 3, v16[i].r);
            chk($sformatf("v16_%0d_z", i), {31'b0, o_z}, {31'b0, v16[i].z});
            if (v16[i].op == 3'd5) begin
                chk($sformatf("v16_%0d_hi", i), o_hi, v16[i].h);
                chk($sformatf("v16_%0d_lo", i), o_lo, v16[i].l);
            end
        end
        wr(0, 32'h0055);
        chk_reg("r0_ext_drop", 0, 32'h0);
        wr(2, 32'h0007);
        run_op("r0_src", 3'd2, 0, 2, 5, 3);
        chk_reg("r0_src_r5", 5, 32'h0007);
        run_op("r0_wb", 3'd2, 2, 2, 0, 3);
        chk_reg("r0_wb_drop", 0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
